serial_cla_adder: RTL and testbench

Multi-cycle adder that computes a WIDTH-bit sum two bits per clock using an internal 2-bit carry-lookahead slice.

- The slice has a carry-in. Carry is registered between slices.
- Sits upstream of the result display/consumer logic and downstream of the operand switches.
- Lets wide operands share one small lookahead slice instead of a full-width adder.

---
 rtl/serial_cla_adder.sv | 145 ++++++++++++++
 tb/tb_serial_cla_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cla_adder.sv
// serial_cla_adder: WIDTH-bit adder that walks the operands two bits per
// clock through one 2-bit carry-lookahead slice, carrying between steps in
// a register. Result (sum/cout) is registered and held until the next
// completion.
//
// Optional feature macro: SERIAL_CLA_SUB_EN adds a 'sub' input that turns
// the operation into a - b (cout=1 means no borrow).
//
// state | meaning
// IDLE  | waiting for start, result held
// RUN   | one slice step per cycle, STEPS cycles
// DONE  | one-cycle done pulse, start accepted here too

module serial_cla_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_CLA_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STEPS = WIDTH / 2;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [SW-1:0]    step_q, step_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sub_in;
    logic [1:0]       g, p, s;
    logic             c1, c2;
    logic [WIDTH-1:0] psum_shift;

`ifdef SERIAL_CLA_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // 2-bit lookahead slice on the low bits of the operand shifters
    always_comb begin
        g  = opa_q[1:0] & opb_q[1:0];
        p  = opa_q[1:0] ^ opb_q[1:0];
        c1 = g[0] | (p[0] & carry_q);
        c2 = g[1] | (p[1] & c1);
        s  = p ^ {c1, carry_q};
        // new slice bits enter at the top so the LSB pair ends up at [1:0]
        psum_shift = (psum_q >> 2) | (WIDTH'(s) << (WIDTH - 2));
    end

    // next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        step_d  = step_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    opa_d   = a;
                    opb_d   = sub_in ? ~b : b;
                    carry_d = sub_in;
                    step_d  = '0;
                    psum_d  = '0;
                end
            end
            ST_RUN: begin
                opa_d   = opa_q >> 2;
                opb_d   = opb_q >> 2;
                psum_d  = psum_shift;
                carry_d = c2;
                step_d  = step_q + SW'(1);
                if (step_q == SW'(STEPS - 1)) begin
                    state_d = ST_DONE;
                    sum_d   = psum_shift;
                    cout_d  = c2;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // state and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            step_q  <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            step_q  <= step_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_cla_adder.sv
// Bench for serial_cla_adder: arithmetic model plus directed vectors.
// Define SERIAL_CLA_SUB_EN to also exercise subtraction.

module tb_serial_cla_adder;

    localparam int W     = 8;
    localparam int STEPS = W / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start2 = 1'b0;
    logic         sub2 = 1'b0;
    logic [1:0]   a2 = '0, b2 = '0;
    logic         busy2, done2, cout2;
    logic [1:0]   sum2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_cla_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERIAL_CLA_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_cla_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef SERIAL_CLA_SUB_EN
        .sub(sub2),
`endif
        .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted operation produces a+b (or a+~b+1) after STEPS busy cycles.
    logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic [W:0]   m_res = '0;
    int           m_age = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_age = 0;
        end else if (m_busy) begin
            m_done = 1'b0;
            m_age++;
            if (m_age == STEPS) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_sum  = m_res[W-1:0];
                m_cout = m_res[W];
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_busy = 1'b1;
                m_age  = 0;
`ifdef SERIAL_CLA_SUB_EN
                m_res  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
`else
                m_res  = {1'b0, a} + {1'b0, b};
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("sum", sum, m_sum);
            check("cout", cout, m_cout);
        end
    end

    // Drive an operation from the current negedge and wait (bounded) for done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                          output int n, output int nbusy);
        a = ta; b = tb_; sub = ts; start = 1'b1;
        n = 0; nbusy = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (busy) nbusy++;
        end while (!done && n < 20);
    endtask

    int n, nb, ndone;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h5A, 8'h3C, 1'b0, n, nb);
        check("lat_5a3c", n, 5);
        check("busy_cycles", nb, 4);
        check("sum_5a3c", sum, 8'h96);
        check("cout_5a3c", cout, 0);
        @(negedge clk);

        run_op(8'hFF, 8'h01, 1'b0, n, nb);
        check("sum_ff01", sum, 8'h00);
        check("cout_ff01", cout, 1);
        // start issued in the done cycle must be accepted
        run_op(8'hAA, 8'h55, 1'b0, n, nb);
        check("b2b_lat", n, 5);
        check("sum_aa55", sum, 8'hFF);
        check("cout_aa55", cout, 0);
        @(negedge clk);

        // start during RUN is ignored
        a = 8'h01; b = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_sum", sum, 8'hFF);
        n = 3;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ign_lat", n, 5);
        check("sum_0102", sum, 8'h03);
        repeat (8) @(negedge clk);
        check("no_extra_busy", busy, 0);

        // reset in the second RUN cycle discards the operation
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_rst", ndone, 0);

        // reset together with start: start ignored
        rst_n = 1'b0; start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", busy, 0);

`ifdef SERIAL_CLA_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, n, nb);
        check("sub_1001_sum", sum, 8'h0F);
        check("sub_1001_cout", cout, 1);
        @(negedge clk);
        run_op(8'h01, 8'h02, 1'b1, n, nb);
        check("sub_0102_sum", sum, 8'hFF);
        check("sub_0102_cout", cout, 0);
        @(negedge clk);
        run_op(8'h37, 8'h21, 1'b0, n, nb);
        check("sub0_sum", sum, 8'h58);
        sub = 1'b0;
        @(negedge clk);
`endif

        // WIDTH=2 instance
        a2 = 2'h3; b2 = 2'h3; start2 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start2 = 1'b0;
            n++;
        end while (!done2 && n < 20);
        check("w2_lat", n, 2);
        check("w2_sum", sum2, 2'h2);
        check("w2_cout", cout2, 1);
        @(negedge clk);
        check("w2_done_pulse", done2, 0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
